// File: rtl/clb_cfg_pkg.sv
// Shared types and helpers for the CLB configuration loader.
// Optional feature macro: CLB_CFG_PARITY_EN (adds a per-frame even-parity bit).
package clb_cfg_pkg;

    typedef enum logic {
        CFG_LOAD = 1'b0,
        CFG_DONE = 1'b1
    } cfg_state_t;

    // Position inside the current BLE frame
    typedef enum logic [1:0] {
        PH_MODE   = 2'd0,
        PH_DATA   = 2'd1,
        PH_PARITY = 2'd2
    } cfg_phase_t;

    // LUT words per BLE
    function automatic int clb_depth(input int width);
        return 1 << width;
    endfunction

    // Bits per BLE frame: mode bit, all LUT words, optional parity bit
    function automatic int frame_bits(input int width, input bit parity);
        return 1 + clb_depth(width) * width + (parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/clb_cfg_loader_deser.sv
// Word deserialiser: collects CLB_WIDTH scan bits MSB-first and flags the
// cycle on which the final bit of a word arrives.
module cfg_deser
    import clb_cfg_pkg::*;
#(
    parameter int CLB_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 shift_en,
    input  logic                 bit_in,
    output logic [CLB_WIDTH-1:0] word,
    output logic                 word_valid
);

    localparam int CNT_W = (CLB_WIDTH > 1) ? $clog2(CLB_WIDTH) : 1;

    logic [CLB_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;

    assign word       = (shreg << 1) | CLB_WIDTH'(bit_in);
    assign word_valid = shift_en && (bit_cnt == CNT_W'(CLB_WIDTH - 1));

    // Shift in one bit per accepted data cycle; counter restarts after each word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= word;
            bit_cnt <= word_valid ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clb_cfg_loader.sv
// CLB configuration front end: turns the scan chain into per-BLE LUT writes
// and mode bits, then bypasses further scan bits to the next CLB.
// Optional feature macro: CLB_CFG_PARITY_EN (frame parity bit and cfg_err).
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int CLB_WIDTH = 4,
    parameter int CLB_NUM   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 scan_en,
    input  logic                 scan_in,
    output logic                 scan_out,
    output logic [CLB_NUM-1:0]   cfg_we,
    output logic [CLB_WIDTH-1:0] cfg_addr,
    output logic [CLB_WIDTH-1:0] cfg_data,
    output logic [CLB_NUM-1:0]   cfg_is_comb,
    output logic                 cfg_done
`ifdef CLB_CFG_PARITY_EN
    ,
    output logic                 cfg_err
`endif
);

    localparam int DEPTH = clb_depth(CLB_WIDTH);
    localparam int BLE_W = (CLB_NUM > 1) ? $clog2(CLB_NUM) : 1;

    cfg_state_t           state, state_next;
    cfg_phase_t           phase;
    logic [CLB_WIDTH-1:0] word_cnt;
    logic [BLE_W-1:0]     ble;
    logic [CLB_NUM-1:0]   ble_onehot;
    logic [CLB_WIDTH-1:0] word;
    logic                 word_valid;
    logic                 load_active;
    logic                 accept;
    logic                 data_shift;
    logic                 word_last;
    logic                 ble_last;
    logic                 frame_end;
`ifdef CLB_CFG_PARITY_EN
    logic                 par_acc;
`endif

    assign accept     = scan_en && load_active;
    assign data_shift = accept && (phase == PH_DATA);
    assign word_last  = (word_cnt == CLB_WIDTH'(DEPTH - 1));
    assign ble_last   = (ble == BLE_W'(CLB_NUM - 1));
`ifdef CLB_CFG_PARITY_EN
    assign frame_end  = accept && (phase == PH_PARITY);
`else
    assign frame_end  = data_shift && word_valid && word_last;
`endif

    cfg_deser #(.CLB_WIDTH(CLB_WIDTH)) u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (data_shift),
        .bit_in     (scan_in),
        .word       (word),
        .word_valid (word_valid)
    );

    // Decode the active BLE into its write strobe
    always_comb begin
        ble_onehot = '0;
        for (int i = 0; i < CLB_NUM; i++) begin
            if (ble == BLE_W'(i)) ble_onehot[i] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CFG_LOAD;
        else        state <= state_next;
    end

    // Leave LOAD once the last frame of the last BLE has been consumed
    always_comb begin
        state_next = state;
        if (state == CFG_LOAD && frame_end && ble_last) state_next = CFG_DONE;
    end

    // State-derived outputs
    always_comb begin
        load_active = (state == CFG_LOAD);
        cfg_done    = (state == CFG_DONE);
    end

    // Frame walker: mode capture, word writes, counters and parity check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= PH_MODE;
            word_cnt    <= '0;
            ble         <= '0;
            cfg_we      <= '0;
            cfg_addr    <= '0;
            cfg_data    <= '0;
            cfg_is_comb <= '0;
`ifdef CLB_CFG_PARITY_EN
            par_acc     <= 1'b0;
            cfg_err     <= 1'b0;
`endif
        end else begin
            cfg_we <= '0;
            if (accept) begin
                case (phase)
                    PH_MODE: begin
                        cfg_is_comb[ble] <= scan_in;
                        phase            <= PH_DATA;
`ifdef CLB_CFG_PARITY_EN
                        par_acc          <= scan_in;
`endif
                    end
                    PH_DATA: begin
`ifdef CLB_CFG_PARITY_EN
                        par_acc <= par_acc ^ scan_in;
`endif
                        if (word_valid) begin
                            cfg_we   <= ble_onehot;
                            cfg_addr <= word_cnt;
                            cfg_data <= word;
                            if (word_last) begin
                                word_cnt <= '0;
`ifdef CLB_CFG_PARITY_EN
                                phase    <= PH_PARITY;
`else
                                phase    <= PH_MODE;
                                ble      <= ble_last ? '0 : ble + 1'b1;
`endif
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end
                    end
                    PH_PARITY: begin
`ifdef CLB_CFG_PARITY_EN
                        if (par_acc ^ scan_in) cfg_err <= 1'b1;
`endif
                        phase <= PH_MODE;
                        ble   <= ble_last ? '0 : ble + 1'b1;
                    end
                    default: phase <= PH_MODE;
                endcase
            end
        end
    end

    // Daisy-chain bypass once this CLB is configured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          scan_out <= 1'b0;
        else if (state == CFG_DONE && scan_en) scan_out <= scan_in;
    end

endmodule
